// File: rtl/guess_entry.sv
// Player guess-entry front end: synchronises, debounces and edge-detects five buttons,
// edits a four-slot colour guess and offers it over valid/ready. Debouncer enabled by GUESS_ENTRY_DEBOUNCE_EN.
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_COLOR       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_submit,
  input  logic        view_history,
  input  logic        guess_ready,
  output logic [2:0]  guess_rgb0,
  output logic [2:0]  guess_rgb1,
  output logic [2:0]  guess_rgb2,
  output logic [2:0]  guess_rgb3,
  output logic [1:0]  blink_led,
  output logic        blink_enable,
  output logic        guess_valid,
  output logic [11:0] guess_word
);

  localparam int NB = 5;
  // Button bit positions inside the packed vectors below.
  localparam int B_RIGHT = 0, B_LEFT = 1, B_DOWN = 2, B_UP = 3, B_SUBMIT = 4;
  localparam logic [2:0] MAX_C = 3'(MAX_COLOR);

  typedef enum logic {EDIT, OFFER} state_t;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] level;
  logic [NB-1:0] prev_q, pulse_q;

  assign btn_raw = {btn_submit, btn_up, btn_down, btn_left, btn_right};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef GUESS_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NB-1:0]         level_q;
  logic [NB-1:0][CW-1:0] cnt_q;

  // NOTE: the counter array is tiny and reset explicitly; large RAM-style arrays would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_q[i] <= sync2_q[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign level = level_q;
`else
  assign level = sync2_q;
`endif

  // Registered rising-edge pulse; releases never produce a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      pulse_q <= '0;
    end else begin
      prev_q  <= level;
      pulse_q <= level & ~prev_q;
    end
  end

  function automatic logic [2:0] color_up(input logic [2:0] c);
    return (c == 3'd0 || c >= MAX_C) ? 3'd1 : c + 3'd1;
  endfunction

  function automatic logic [2:0] color_down(input logic [2:0] c);
    return (c <= 3'd1) ? MAX_C : c - 3'd1;
  endfunction

  state_t          state_q, state_d;
  logic [3:0][2:0] slot_q, slot_d;
  logic [1:0]      cursor_q, cursor_d;
  logic            all_filled;

  assign all_filled = (slot_q[0] != 3'd0) && (slot_q[1] != 3'd0) &&
                      (slot_q[2] != 3'd0) && (slot_q[3] != 3'd0);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    cursor_d = cursor_q;
    case (state_q)
      EDIT: begin
        if (!view_history) begin
          if (pulse_q[B_SUBMIT]) begin
            if (all_filled) state_d = OFFER;
          end else if (pulse_q[B_UP]) begin
            slot_d[cursor_q] = color_up(slot_q[cursor_q]);
          end else if (pulse_q[B_DOWN]) begin
            slot_d[cursor_q] = color_down(slot_q[cursor_q]);
          end else if (pulse_q[B_LEFT]) begin
            cursor_d = cursor_q - 2'd1;
          end else if (pulse_q[B_RIGHT]) begin
            cursor_d = cursor_q + 2'd1;
          end
        end
      end
      OFFER: begin
        if (guess_ready) begin
          state_d  = EDIT;
          slot_d   = '0;
          cursor_d = '0;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EDIT;
      slot_q   <= '0;
      cursor_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cursor_q <= cursor_d;
    end
  end

  assign guess_rgb0   = slot_q[0];
  assign guess_rgb1   = slot_q[1];
  assign guess_rgb2   = slot_q[2];
  assign guess_rgb3   = slot_q[3];
  assign guess_word   = slot_q;
  assign blink_led    = cursor_q;
  assign guess_valid  = (state_q == OFFER);
  assign blink_enable = (state_q == EDIT) && !view_history;

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry: a table of single presses with expected outputs,
// then hand-written sequences for the handshake, async reset and hold/glitch behaviour.
module tb_guess_entry;

`ifdef GUESS_ENTRY_DEBOUNCE_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = LAT + 3;

  localparam logic [4:0] B_SUB = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100,
                         B_LF  = 5'b00010, B_RT = 5'b00001, B_NONE = 5'b00000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0, btn_submit = 0;
  logic        view_history = 0, guess_ready = 0;
  logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
  logic [1:0]  blink_led;
  logic        blink_enable, guess_valid;
  logic [11:0] guess_word;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  guess_entry #(.DEBOUNCE_CYCLES(10), .MAX_COLOR(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_submit(btn_submit),
    .view_history(view_history), .guess_ready(guess_ready),
    .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1),
    .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
    .blink_led(blink_led), .blink_enable(blink_enable),
    .guess_valid(guess_valid), .guess_word(guess_word)
  );

  typedef struct packed {
    logic [4:0]  btn;
    logic        vh;
    logic [11:0] word;
    logic [1:0]  cur;
    logic        en;
    logic        valid;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] b);
    {btn_submit, btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  task automatic press(input logic [4:0] b);
    @(negedge clk);
    drive(b);
    repeat (HOLD) @(negedge clk);
    drive(B_NONE);
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic fill_ones();
    press(B_UP); press(B_RT); press(B_UP); press(B_RT);
    press(B_UP); press(B_RT); press(B_UP);
  endtask

  initial begin
    bit seen;
    vecs[0]  = '{B_UP,        1'b0, 12'h001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{B_UP,        1'b0, 12'h002, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{B_UP,        1'b0, 12'h003, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{B_UP,        1'b0, 12'h004, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{B_UP,        1'b0, 12'h005, 2'd0, 1'b1, 1'b0};
    vecs[5]  = '{B_UP,        1'b0, 12'h006, 2'd0, 1'b1, 1'b0};
    vecs[6]  = '{B_UP,        1'b0, 12'h001, 2'd0, 1'b1, 1'b0};
    vecs[7]  = '{B_RT,        1'b0, 12'h001, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{B_DN,        1'b0, 12'h031, 2'd1, 1'b1, 1'b0};
    vecs[9]  = '{B_LF,        1'b0, 12'h031, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{B_LF,        1'b0, 12'h031, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{B_RT,        1'b0, 12'h031, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{B_RT,        1'b0, 12'h031, 2'd1, 1'b1, 1'b0};
    vecs[13] = '{B_SUB,       1'b0, 12'h031, 2'd1, 1'b1, 1'b0};
    vecs[14] = '{B_UP,        1'b0, 12'h009, 2'd1, 1'b1, 1'b0};
    vecs[15] = '{B_UP,        1'b0, 12'h011, 2'd1, 1'b1, 1'b0};
    vecs[16] = '{B_RT,        1'b0, 12'h011, 2'd2, 1'b1, 1'b0};
    vecs[17] = '{B_UP,        1'b0, 12'h051, 2'd2, 1'b1, 1'b0};
    vecs[18] = '{B_UP,        1'b0, 12'h091, 2'd2, 1'b1, 1'b0};
    vecs[19] = '{B_UP,        1'b0, 12'h0D1, 2'd2, 1'b1, 1'b0};
    vecs[20] = '{B_RT,        1'b0, 12'h0D1, 2'd3, 1'b1, 1'b0};
    vecs[21] = '{B_DN,        1'b0, 12'hCD1, 2'd3, 1'b1, 1'b0};
    vecs[22] = '{B_DN,        1'b0, 12'hAD1, 2'd3, 1'b1, 1'b0};
    vecs[23] = '{B_DN,        1'b0, 12'h8D1, 2'd3, 1'b1, 1'b0};
    vecs[24] = '{B_UP | B_LF, 1'b0, 12'hAD1, 2'd3, 1'b1, 1'b0};
    vecs[25] = '{B_DN | B_RT, 1'b0, 12'h8D1, 2'd3, 1'b1, 1'b0};
    vecs[26] = '{B_UP,        1'b1, 12'h8D1, 2'd3, 1'b0, 1'b0};
    vecs[27] = '{B_LF,        1'b1, 12'h8D1, 2'd3, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_word",  32'(guess_word),   32'h000);
    check("reset_blink", 32'(blink_led),    32'd0);
    check("reset_en",    32'(blink_enable), 32'd1);
    check("reset_valid", 32'(guess_valid),  32'd0);

    for (int i = 0; i < NV; i++) begin
      view_history = vecs[i].vh;
      press(vecs[i].btn);
      check($sformatf("v%0d_word", i),  32'(guess_word),   32'(vecs[i].word));
      check($sformatf("v%0d_cur", i),   32'(blink_led),    32'(vecs[i].cur));
      check($sformatf("v%0d_en", i),    32'(blink_enable), 32'(vecs[i].en));
      check($sformatf("v%0d_valid", i), 32'(guess_valid),  32'(vecs[i].valid));
    end
    view_history = 1'b0;

    // Offer {4,3,2,1} with guess_ready held low, then accept.
    press(B_SUB);
    check("a_valid", 32'(guess_valid), 32'd1);
    check("a_word",  32'(guess_word),  32'h8D1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("a_hold%0d_valid", i), 32'(guess_valid), 32'd1);
      check($sformatf("a_hold%0d_word", i),  32'(guess_word),  32'h8D1);
    end
    press(B_UP);
    check("a_frozen_word", 32'(guess_word),   32'h8D1);
    check("a_offer_en",    32'(blink_enable), 32'd0);
    guess_ready = 1'b1;
    @(negedge clk);
    guess_ready = 1'b0;
    check("a_done_valid", 32'(guess_valid), 32'd0);
    check("a_done_word",  32'(guess_word),  32'h000);
    check("a_done_cur",   32'(blink_led),   32'd0);

    // guess_ready already high when the offer appears: one-cycle transfer.
    fill_ones();
    check("b_fill_word", 32'(guess_word), 32'h249);
    guess_ready = 1'b1;
    @(negedge clk);
    drive(B_SUB);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (guess_valid) seen = 1'b1;
    end
    check("b_valid_rise", 32'(seen), 32'd1);
    @(negedge clk);
    check("b_xfer_valid", 32'(guess_valid), 32'd0);
    check("b_xfer_word",  32'(guess_word),  32'h000);
    drive(B_NONE);
    repeat (HOLD) @(negedge clk);
    guess_ready = 1'b0;
    check("b_idle_valid", 32'(guess_valid), 32'd0);

    // Reset asserted while offering clears everything without a clock edge.
    fill_ones();
    press(B_SUB);
    check("c_valid", 32'(guess_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("c_rst_valid", 32'(guess_valid), 32'd0);
    check("c_rst_word",  32'(guess_word),  32'h000);
    check("c_rst_cur",   32'(blink_led),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("c_after_en", 32'(blink_enable), 32'd1);

`ifdef GUESS_ENTRY_DEBOUNCE_EN
    @(negedge clk);
    btn_up = 1'b1;
    repeat (5) @(negedge clk);
    btn_up = 1'b0;
    repeat (30) @(negedge clk);
    check("glitch_word", 32'(guess_word), 32'h000);
`endif

    // A long hold yields exactly one step.
    @(negedge clk);
    btn_up = 1'b1;
    repeat (40) @(negedge clk);
    btn_up = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("hold_word", 32'(guess_word), 32'h001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
# guess_entry

Player-input front end for the guess/history display path. Debounces five push-buttons, maintains a four-slot colour guess with a cursor, and drives the guess colours, cursor index and blink enable consumed by the LED display driver. A completed guess is offered to the game logic over a valid/ready handshake and cleared once accepted.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level change is accepted (≥1)
- MAX_COLOR, 6, highest colour code; legal colours are 1..MAX_COLOR (2..7); 0 means empty slot

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_left  input  1  raw button, move cursor down
- btn_right  input  1  raw button, move cursor up
- btn_up  input  1  raw button, next colour in cursor slot
- btn_down  input  1  raw button, previous colour in cursor slot
- btn_submit  input  1  raw button, offer guess
- view_history  input  1  level; high = display shows history, edits frozen
- guess_ready  input  1  game logic accepts guess
- guess_rgb0..guess_rgb3  output  3 each  slot colours
- blink_led  output  2  cursor slot index
- blink_enable  output  1  high = display in guess mode
- guess_valid  output  1  guess offered
- guess_word  output  12  {guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0}

## Operation
- Per button: two-flop synchroniser, debouncer, rising-edge detector producing a one-cycle press pulse. Releases produce no pulse.
- States: EDIT, OFFER. Reset: EDIT, all slots 0, blink_led 0, guess_valid 0, blink_enable 1 (if view_history low), debouncer levels 0, counters 0.
- EDIT, view_history low, one pulse per cycle, priority submit > up > down > left > right; lower-priority pulses in the same cycle are discarded.
  - up: slot 0 → 1, k → k+1, MAX_COLOR → 1.
  - down: slot 0 → MAX_COLOR, k → k−1, 1 → MAX_COLOR.
  - left: blink_led − 1 mod 4 (0 → 3). right: +1 mod 4 (3 → 0).
  - submit: if all four slots non-zero → OFFER, guess_valid 1; else ignored.
- EDIT, view_history high: all pulses discarded; slots and cursor hold.
- OFFER: all pulses discarded; slots frozen; guess_valid held until a cycle with guess_ready high; on that edge slots → 0, blink_led → 0, guess_valid → 0, state → EDIT.
- guess_ready outside OFFER is ignored.
- blink_enable = (state == EDIT) && !view_history, combinational; guess_word combinational from slots.

## Timing
- Debouncer: accepted level changes when synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle resets the counter.
- Latency: raw press first sampled at edge t → slot/cursor/guess_valid update visible after edge t+DEBOUNCE_CYCLES+3 (t+3 without debounce).
- Handshake transfer on any edge where guess_valid && guess_ready; guess_valid may assert with guess_ready already high → transfer one cycle after assertion.
- Reset asserted mid-OFFER: guess_valid drops immediately (asynchronous), slots clear, no transfer.
- Button held: exactly one pulse per press regardless of hold length.

## Configuration
- GUESS_ENTRY_DEBOUNCE_EN defined: debouncer present as above, DEBOUNCE_CYCLES honoured.
- Not defined: debouncer removed; accepted level = synchroniser output; DEBOUNCE_CYCLES ignored; latency t+3. Intended for simulation and bench speed.

## Test plan
- Reset, no presses → guess_word 12'h000, blink_led 0, blink_enable 1, guess_valid 0.
- up ×7 with MAX_COLOR 6 on slot 0 → guess_rgb0 sequence 1,2,3,4,5,6,1; down once from 0 on slot 1 → guess_rgb1 6.
- left from cursor 0 → blink_led 3; right ×2 → 1; glitch on btn_up shorter than DEBOUNCE_CYCLES (10) → no change.
- Submit with slot 2 empty → guess_valid stays 0; fill all slots to {4,3,2,1}, submit with guess_ready low 5 cycles then high → guess_valid high 5+ cycles, guess_word 12'h8D1 held, then slots 0, valid 0.
- up and left pressed same cycle → only colour changes; view_history high → blink_enable 0, presses ignored.
- rst_n low during OFFER → guess_valid 0 asynchronously, state EDIT, slots 0.
